// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial front end for the sequence identifier.
// Accepts DATA_W-bit words on a valid/ready handshake and emits them one bit
// per clock on bit_o. A one-word holding register lets a new word be taken
// while the previous one is still shifting, so words stream with no gaps.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   data_i       word to serialize, sampled on valid_i && ready_o
//   valid_i      data_i holds a word
//   ready_o      a word can be accepted this cycle (registers only)
//   bit_o        serial bit, 0 while idle
//   bit_valid_o  bit_o carries a payload bit
//   last_o       bit_o carries the final bit of a word
//   busy_o       shifter active or holding register occupied
module seq_serializer #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              bit_o,
  output logic              bit_valid_o,
  output logic              last_o,
  output logic              busy_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic at_last;
  logic load;
  logic accept;

  assign at_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  // The shifter takes the held word when idle or on the last bit of the
  // current word, which is what makes back-to-back streaming gap-free.
  assign load    = hold_full_q && ((state_q == IDLE) || at_last);
  assign accept  = valid_i && ready_o;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE:    if (load) state_d = SHIFT;
      SHIFT:   if (at_last && !load) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load) begin
      sh_d  = hold_q;
      cnt_d = '0;
    end else if ((state_q == SHIFT) && !at_last) begin
      sh_d  = MSB_FIRST ? {sh_q[DATA_W-2:0], 1'b0} : {1'b0, sh_q[DATA_W-1:1]};
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Accept wins over the load-clear: on a simultaneous edge the old word
    // has already moved into sh_d above and the new one takes its place.
    if (accept) begin
      hold_d      = data_i;
      hold_full_d = 1'b1;
    end else if (load) begin
      hold_full_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    ready_o     = !hold_full_q || load;
    bit_valid_o = (state_q == SHIFT);
    last_o      = at_last;
    busy_o      = (state_q == SHIFT) || hold_full_q;
    bit_o       = 1'b0;
    if (state_q == SHIFT) bit_o = MSB_FIRST ? sh_q[DATA_W-1] : sh_q[0];
  end

endmodule

// File: tb/tb_seq_serializer.sv
module tb_seq_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data;
  logic         valid;

  logic rdy_m, bit_m, bv_m, last_m, busy_m;
  logic rdy_l, bit_l, bv_l, last_l, busy_l;

  always #5 clk = ~clk;

  seq_serializer #(.DATA_W(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid),
    .ready_o(rdy_m), .bit_o(bit_m), .bit_valid_o(bv_m),
    .last_o(last_m), .busy_o(busy_m)
  );

  seq_serializer #(.DATA_W(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid),
    .ready_o(rdy_l), .bit_o(bit_l), .bit_valid_o(bv_l),
    .last_o(last_l), .busy_o(busy_l)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a word in flight with a count of bits still to send,
  // plus an optional waiting word.
  int           m_left;
  logic [W-1:0] m_cur;
  logic [W-1:0] m_hold;
  bit           m_hf;

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  function automatic logic m_ready();
    return (!m_hf) || (m_left <= 1);
  endfunction

  task automatic model_reset();
    m_left = 0;
    m_cur  = '0;
    m_hold = '0;
    m_hf   = 1'b0;
  endtask

  task automatic check_outputs(input string ph);
    logic eb_m, eb_l;
    eb_m = 1'b0;
    eb_l = 1'b0;
    if (m_left > 0) begin
      eb_m = m_cur[m_left - 1];
      eb_l = m_cur[W - m_left];
    end
    chk({ph, ".ready_msb"}, rdy_m, m_ready());
    chk({ph, ".bit_msb"},   bit_m, eb_m);
    chk({ph, ".bv_msb"},    bv_m,  m_left > 0);
    chk({ph, ".last_msb"},  last_m, m_left == 1);
    chk({ph, ".busy_msb"},  busy_m, (m_left > 0) || m_hf);
    chk({ph, ".ready_lsb"}, rdy_l, m_ready());
    chk({ph, ".bit_lsb"},   bit_l, eb_l);
    chk({ph, ".bv_lsb"},    bv_l,  m_left > 0);
    chk({ph, ".last_lsb"},  last_l, m_left == 1);
    chk({ph, ".busy_lsb"},  busy_l, (m_left > 0) || m_hf);
  endtask

  // One clock: check outputs, then advance the model across the edge.
  task automatic cycle(input string ph, output bit acc);
    check_outputs(ph);
    acc = valid && m_ready();
    @(posedge clk);
    if (m_left > 0) m_left--;
    if (m_left == 0 && m_hf) begin
      m_cur  = m_hold;
      m_left = W;
      m_hf   = 1'b0;
    end
    if (acc) begin
      m_hold = data;
      m_hf   = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic send(input string ph, input logic [W-1:0] w);
    bit acc;
    acc   = 1'b0;
    data  = w;
    valid = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) cycle(ph, acc);
    chk({ph, ".accept_in_time"}, acc, 1'b1);
  endtask

  task automatic idle_cycles(input string ph, input int n);
    bit acc;
    valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(ph, acc);
  endtask

  initial begin
    bit acc;
    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;

    // Single word
    send("single", 8'hA5);
    idle_cycles("single", 11);

    // Back-to-back with backpressure on the third word
    send("b2b", 8'hA5);
    send("b2b", 8'h3C);
    send("b2b", 8'hFF);
    idle_cycles("b2b", 26);

    // LSB-first word with a single set bit
    send("lsb", 8'h01);
    idle_cycles("lsb", 10);

    // Reset in the middle of a word while another is held
    send("midrst", 8'hA5);
    send("midrst", 8'h3C);
    idle_cycles("midrst", 2);
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    check_outputs("in_rst");
    rst = 1'b0;
    idle_cycles("after_rst", 20);

    // Randomized traffic; data held stable until accepted
    valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!valid) begin
        valid = ($urandom_range(0, 3) != 0);
        data  = W'($urandom);
      end
      cycle("rand", acc);
      if (acc) valid = 1'b0;
      if (acc && $urandom_range(0, 1) == 1) begin
        valid = 1'b1;
        data  = W'($urandom);
      end
    end
    idle_cycles("drain", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
